// File: rtl/lze_seq.sv
// Round-trip sequencer for the LZE codec: feeds a buffered string to the encoder,
// captures the emitted triples, replays them as decode commands and checks the result.
module lze_seq #(
    parameter int          MAX_LEN = 16,
    parameter logic [7:0]  TERM    = 8'h45,
    parameter int          TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] str_data,
    input  logic       start,
    output logic       code_valid,
    output logic [3:0] code_pos,
    output logic [3:0] code_len,
    output logic [7:0] chardata,
    input  logic       valid,
    input  logic       encode,
    input  logic       busy,
    input  logic [3:0] offset,
    input  logic [3:0] match_len,
    input  logic [7:0] char_nxt,
    output logic       seq_busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [4:0] trip_cnt,
    output logic [1:0] abort
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ENC_FEED, ENC_WAIT, DEC_ISSUE, DEC_WAIT, DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    str_buf [MAX_LEN];
    logic [15:0]   trip    [MAX_LEN];
    logic [4:0]    wptr, idx, d, k, exp_cnt;
    logic [WW-1:0] wdog;
    logic          rearm;

    logic          start_ok, enc_hit, dec_hit, wd_fire, ovf;
    logic          last_byte, run_end, dec_mis, len_err;
    logic [4:0]    d_nxt, err_nxt;
    logic [5:0]    err_sum;
    logic [15:0]   cur_trip;
    logic          unused_busy;

    // busy from LZE is status only; sequencing relies on valid alone
    assign unused_busy = busy;

    assign start_ok  = start && (wptr != 5'd0) &&
                       (((state == IDLE) && !wr_en) || (state == DONE));
    assign enc_hit   = valid && encode;
    assign dec_hit   = valid && !encode;
    assign cur_trip  = trip[k[AW-1:0]];
    assign wd_fire   = ((state == ENC_WAIT) || (state == DEC_WAIT)) && !valid &&
                       (wdog == WW'(TIMEOUT - 1));
    assign ovf       = enc_hit && (char_nxt != TERM) && (trip_cnt == 5'(MAX_LEN - 1));

    // Decoded-byte checking: bytes past the string must be the terminator
    always_comb begin
        dec_mis = 1'b0;
        if (state == DEC_WAIT && valid) begin
            if (encode)
                dec_mis = 1'b1;
            else if (d < wptr)
                dec_mis = (char_nxt != str_buf[d[AW-1:0]]);
            else
                dec_mis = (char_nxt != TERM);
        end
    end

    assign d_nxt     = d + 5'((state == DEC_WAIT) && dec_hit && (d < wptr));
    assign last_byte = (state == DEC_WAIT) && dec_hit && (exp_cnt == 5'd1);
    assign run_end   = last_byte && (k + 5'd1 == trip_cnt);
    assign len_err   = run_end && (d_nxt != wptr);
    assign err_sum   = {1'b0, err_cnt} + 6'(dec_mis) + 6'(len_err);
    assign err_nxt   = (err_sum > 6'd31) ? 5'd31 : err_sum[4:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        code_valid = 1'b0;
        code_pos   = 4'd0;
        code_len   = 4'd0;
        chardata   = 8'd0;
        case (state)
            IDLE: if (start_ok) state_nxt = ENC_FEED;
            ENC_FEED: begin
                code_valid = 1'b1;
                chardata   = str_buf[idx[AW-1:0]];
                if (idx + 5'd1 == wptr) state_nxt = ENC_WAIT;
            end
            ENC_WAIT: begin
                chardata = TERM;
                if (wd_fire)                             state_nxt = DONE;
                else if (enc_hit && (char_nxt == TERM))  state_nxt = DEC_ISSUE;
                else if (ovf)                            state_nxt = DONE;
            end
            DEC_ISSUE: begin
                code_valid = 1'b1;
                {code_pos, code_len, chardata} = cur_trip;
                state_nxt  = DEC_WAIT;
            end
            DEC_WAIT: begin
                {code_pos, code_len, chardata} = cur_trip;
                if (wd_fire)        state_nxt = DONE;
                else if (last_byte) state_nxt = run_end ? DONE : DEC_ISSUE;
            end
            DONE: if (start_ok) state_nxt = ENC_FEED;
            default: state_nxt = IDLE;
        endcase
    end

    assign seq_busy = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);

    // Buffers carry no reset; their contents are only read behind valid pointers
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en && wptr != 5'(MAX_LEN))
            str_buf[wptr[AW-1:0]] <= str_data;
        if (state == ENC_WAIT && enc_hit)
            trip[trip_cnt[AW-1:0]] <= {offset, match_len, char_nxt};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            idx      <= '0;
            d        <= '0;
            k        <= '0;
            exp_cnt  <= '0;
            wdog     <= '0;
            rearm    <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            trip_cnt <= '0;
            abort    <= '0;
        end else begin
            if (state == IDLE && wr_en && wptr != 5'(MAX_LEN))
                wptr <= wptr + 5'd1;

            if (state_nxt != state || valid)
                wdog <= '0;
            else if (state == ENC_WAIT || state == DEC_WAIT)
                wdog <= wdog + WW'(1);

            case (state)
                ENC_FEED: idx <= idx + 5'd1;
                ENC_WAIT: begin
                    if (wd_fire) begin
                        abort <= 2'b10;
                    end else if (enc_hit) begin
                        trip_cnt <= trip_cnt + 5'd1;
                        if (char_nxt == TERM) begin
                            k <= '0;
                            d <= '0;
                        end else if (ovf) begin
                            abort <= 2'b01;
                        end
                    end
                end
                DEC_ISSUE: exp_cnt <= {1'b0, cur_trip[11:8]} + 5'd1;
                DEC_WAIT: begin
                    if (wd_fire) begin
                        abort <= 2'b10;
                    end else if (valid) begin
                        err_cnt <= err_nxt;
                        if (dec_hit) begin
                            exp_cnt <= exp_cnt - 5'd1;
                            d       <= d_nxt;
                        end
                        if (last_byte) k <= k + 5'd1;
                        if (run_end)   pass <= (err_nxt == 5'd0);
                    end
                end
                default: ;
            endcase

            // A rerun launched from DONE frees the buffer once it completes
            if (state_nxt == DONE && state != DONE && rearm) begin
                wptr  <= '0;
                rearm <= 1'b0;
            end

            if (start_ok) begin
                idx      <= '0;
                pass     <= 1'b0;
                err_cnt  <= '0;
                trip_cnt <= '0;
                abort    <= '0;
                rearm    <= (state == DONE);
            end
        end
    end

endmodule

// File: tb/tb_lze_seq.sv
// Directed bench for lze_seq; the bench itself plays the LZE codec and
// scoreboards the decode commands it expects the sequencer to replay.
module tb_lze_seq;
    localparam int         MAX_LEN = 16;
    localparam logic [7:0] TERM    = 8'h45;
    localparam int         TIMEOUT = 1024;

    logic       clk = 1'b0, reset = 1'b0;
    logic       wr_en = 1'b0, start = 1'b0;
    logic [7:0] str_data = 8'd0;
    logic       valid = 1'b0, encode = 1'b0, busy = 1'b0;
    logic [3:0] offset = 4'd0, match_len = 4'd0;
    logic [7:0] char_nxt = 8'd0;
    logic       code_valid, seq_busy, done, pass;
    logic [3:0] code_pos, code_len;
    logic [7:0] chardata;
    logic [4:0] err_cnt, trip_cnt;
    logic [1:0] abort;

    int total = 0, bad = 0;
    int cv_cnt = 0;
    logic [15:0] q_issue[$];
    logic [7:0]  q_dec[$];

    lze_seq #(.MAX_LEN(MAX_LEN), .TERM(TERM), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .str_data(str_data), .start(start),
        .code_valid(code_valid), .code_pos(code_pos), .code_len(code_len),
        .chardata(chardata), .valid(valid), .encode(encode), .busy(busy),
        .offset(offset), .match_len(match_len), .char_nxt(char_nxt),
        .seq_busy(seq_busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .trip_cnt(trip_cnt), .abort(abort)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (code_valid) cv_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; wr_en = 1'b0; start = 1'b0; valid = 1'b0; encode = 1'b0;
        #1;
        chk("reset_outs", 32'({code_valid, code_pos, code_len, chardata, seq_busy, done,
                              pass, err_cnt, trip_cnt, abort}), 32'd0);
        tick();
        reset = 1'b1;
        q_issue.delete();
        q_dec.delete();
        tick();
    endtask

    task automatic load(input string s);
        for (int i = 0; i < s.len(); i++) begin
            wr_en = 1'b1; str_data = s[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic go(input string s);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            chk("feed", 32'({code_valid, chardata}), 32'({1'b1, s[i]}));
            tick();
        end
        chk("enc_wait", 32'({code_valid, code_pos, code_len, chardata}),
            32'({1'b0, 4'd0, 4'd0, TERM}));
    endtask

    task automatic emit(input logic [3:0] off, input logic [3:0] ml, input logic [7:0] ch);
        valid = 1'b1; encode = 1'b1; offset = off; match_len = ml; char_nxt = ch;
        q_issue.push_back({off, ml, ch});
        tick();
        valid = 1'b0; encode = 1'b0;
    endtask

    task automatic decode_all();
        logic [15:0] e;
        int c;
        while (q_issue.size() > 0) begin
            e = q_issue.pop_front();
            c = 0;
            while (!code_valid && c < 20) begin tick(); c++; end
            chk("issue", 32'({code_valid, code_pos, code_len, chardata}), 32'({1'b1, e}));
            if (!code_valid) break;
            tick();
            for (int j = 0; j <= int'(e[11:8]); j++) begin
                valid = 1'b1; encode = 1'b0;
                char_nxt = (q_dec.size() > 0) ? q_dec.pop_front() : TERM;
                tick();
            end
            valid = 1'b0;
        end
    endtask

    task automatic fin(input logic p, input logic [4:0] e, input logic [4:0] t,
                       input logic [1:0] a);
        chk("final", 32'({seq_busy, done, pass, err_cnt, trip_cnt, abort, code_valid}),
            32'({1'b0, 1'b1, p, e, t, a, 1'b0}));
    endtask

    initial begin
        int snap, n;

        // single character round trip
        do_reset();
        load("A");
        go("A");
        emit(4'd0, 4'd0, 8'h41);
        emit(4'd0, 4'd0, TERM);
        q_dec = '{8'h41, TERM};
        decode_all();
        fin(1'b1, 5'd0, 5'd2, 2'b00);

        // repeated pattern with a back-reference
        do_reset();
        load("ABAB");
        go("ABAB");
        emit(4'd0, 4'd0, 8'h41);
        emit(4'd0, 4'd0, 8'h42);
        emit(4'd2, 4'd2, TERM);
        q_dec = '{8'h41, 8'h42, 8'h41, 8'h42, TERM};
        decode_all();
        fin(1'b1, 5'd0, 5'd3, 2'b00);

        // third decoded byte corrupted
        do_reset();
        load("ABAB");
        go("ABAB");
        emit(4'd0, 4'd0, 8'h41);
        emit(4'd0, 4'd0, 8'h42);
        emit(4'd2, 4'd2, TERM);
        q_dec = '{8'h41, 8'h42, 8'h43, 8'h42, TERM};
        decode_all();
        fin(1'b0, 5'd1, 5'd3, 2'b00);

        // triple buffer overflow, no terminator ever emitted
        do_reset();
        load("ABCD");
        go("ABCD");
        snap = cv_cnt;
        for (int i = 0; i < MAX_LEN; i++) emit(4'd0, 4'd0, 8'(8'h61 + i));
        q_issue.delete();
        tick(); tick(); tick();
        fin(1'b0, 5'd0, 5'd16, 2'b01);
        chk("no_issue", 32'(cv_cnt - snap), 32'd0);

        // LZE silent after feeding: watchdog
        do_reset();
        load("AB");
        go("AB");
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("pre_timeout", 32'({done, seq_busy}), 32'({1'b0, 1'b1}));
        tick();
        fin(1'b0, 5'd0, 5'd0, 2'b10);

        // reset in the middle of decoding
        do_reset();
        load("A");
        go("A");
        emit(4'd0, 4'd0, 8'h41);
        emit(4'd0, 4'd0, TERM);
        chk("dec_issue", 32'({code_valid, code_pos, code_len, chardata}), 32'({1'b1, 16'h0041}));
        tick();
        chk("dec_wait", 32'({code_valid, seq_busy, chardata}), 32'({1'b0, 1'b1, 8'h41}));
        do_reset();

        // 17 writes keep only 16 bytes
        load("GHIJKLMNOPQRSTUVW");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_byte", 32'(chardata), 32'h47);
        n = 0;
        while (code_valid && n < 40) begin n++; tick(); end
        chk("len_clip", 32'(n), 32'd16);
        do_reset();

        // write and start together: write lands, start ignored
        wr_en = 1'b1; start = 1'b1; str_data = 8'h5a;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("ws_idle", 32'({seq_busy, code_valid}), 32'd0);
        tick();
        chk("ws_still_idle", 32'(seq_busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ws_written", 32'({code_valid, chardata}), 32'({1'b1, 8'h5a}));
        tick();
        chk("ws_enc_wait", 32'({code_valid, chardata}), 32'({1'b0, TERM}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
